alu_issue_ctrl: RTL

- Command issue stage that sits directly upstream of the ALU decoder and function units.
- Accepts one ALU command (function code plus two operands) over a valid/ready handshake and registers it.
- Drives the 2-bit ALU_FUNC class select, the sub-op and the operands for the required number of cycles, captures the ALU result and presents it on a valid/ready result port.
- Handles single-cycle ops and multi-cycle arithmetic (MUL/DIV) with a latency counter.

---
 rtl/alu_issue_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// ALU command issue stage: registers one command, sequences single/multi-cycle execution and
// holds the captured result on a valid/ready port. Define ALU_ISSUE_OP_COUNT_EN to add OP_COUNT.
module alu_issue_ctrl #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned MC_LAT = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CMD_VALID,
  output logic               CMD_READY,
  input  logic [3:0]         CMD_FUN,
  input  logic [WIDTH-1:0]   CMD_A,
  input  logic [WIDTH-1:0]   CMD_B,
  output logic               ALU_EN,
  output logic [1:0]         ALU_FUNC,
  output logic [1:0]         ALU_SUB,
  output logic [WIDTH-1:0]   ALU_A,
  output logic [WIDTH-1:0]   ALU_B,
  input  logic [2*WIDTH-1:0] ALU_RESULT,
  output logic               RES_VALID,
  input  logic               RES_READY,
`ifdef ALU_ISSUE_OP_COUNT_EN
  output logic [15:0]        OP_COUNT,
`endif
  output logic [2*WIDTH-1:0] RES_DATA
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] lat_cnt;
  logic             is_mc;
  logic             cmd_accept;
  logic             capture;
  logic             load_cnt;

  // MUL (00_10) and DIV (00_11) are the only multi-cycle codes
  assign is_mc = (ALU_FUNC == 2'b00) && ALU_SUB[1];

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cmd_accept) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = is_mc ? ST_WAIT : ST_HOLD;
      ST_WAIT: if (lat_cnt == '0) state_nxt = ST_HOLD;
      ST_HOLD: if (RES_READY) state_nxt = cmd_accept ? ST_EXEC : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ALU_EN     = 1'b0;
    RES_VALID  = 1'b0;
    CMD_READY  = 1'b0;
    capture    = 1'b0;
    load_cnt   = 1'b0;
    cmd_accept = 1'b0;
    case (state)
      ST_IDLE: CMD_READY = 1'b1;
      ST_EXEC: begin
        ALU_EN   = 1'b1;
        load_cnt = is_mc;
        capture  = !is_mc;
      end
      ST_WAIT: begin
        ALU_EN  = 1'b1;
        capture = (lat_cnt == '0);
      end
      ST_HOLD: begin
        RES_VALID = 1'b1;
        CMD_READY = RES_READY;
      end
      default: ;
    endcase
    if (RST) CMD_READY = 1'b0;
    cmd_accept = CMD_VALID && CMD_READY;
  end

  // Command registers only move on accept; result only on the final execute cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      ALU_FUNC <= '0;
      ALU_SUB  <= '0;
      ALU_A    <= '0;
      ALU_B    <= '0;
      RES_DATA <= '0;
      lat_cnt  <= '0;
    end else begin
      if (cmd_accept) begin
        ALU_FUNC <= CMD_FUN[3:2];
        ALU_SUB  <= CMD_FUN[1:0];
        ALU_A    <= CMD_A;
        ALU_B    <= CMD_B;
      end
      if (capture) RES_DATA <= ALU_RESULT;
      if (load_cnt)
        lat_cnt <= CNT_W'(MC_LAT - 2);
      else if (state == ST_WAIT && lat_cnt != '0)
        lat_cnt <= lat_cnt - CNT_W'(1);
    end
  end

`ifdef ALU_ISSUE_OP_COUNT_EN
  // Saturating count of result handshakes
  always_ff @(posedge CLK) begin
    if (RST)
      OP_COUNT <= '0;
    else if (RES_VALID && RES_READY && OP_COUNT != 16'hFFFF)
      OP_COUNT <= OP_COUNT + 16'd1;
  end
`endif

endmodule
